ptw_pt_mem: RTL and testbench

Page-table memory responder: the memory-side end of the PTW memory interface. It accepts one word-read request at a time over a valid/ready request channel and returns the addressed 32-bit word over a valid/ready response channel after a configurable latency. A side write port preloads page-table entries (root and L2 tables). It sits between `ptw` and the page-table backing store, and it replaces ad-hoc behavioural memory models in PTW and TLB benches and integration.

---
 rtl/ptw_pt_mem.sv | 145 ++++++++++++++
 tb/tb_ptw_pt_mem.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_pt_mem.sv
// ptw_pt_mem: page-table memory responder for the PTW memory interface.
// It accepts one word read at a time and answers after LATENCY cycles.
// A side write port preloads the table; the array survives rst_n.
// Optional feature macro: PTW_MEM_ERR_EN adds mem_err_o, which flags
// out-of-range and misaligned reads.
//
// Handshake rules for both channels: a transfer happens at a rising edge
// where valid and ready are both 1. The responder's ready and valid are
// registered. Once mem_resp_valid_o is raised, it and mem_data_o hold
// until the transfer.
module ptw_pt_mem #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2        // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_valid_i,
    output logic        mem_req_ready_o,
    input  logic [31:0] mem_addr_i,
    output logic        mem_resp_valid_o,
    input  logic        mem_resp_ready_i,
    output logic [31:0] mem_data_o,
    input  logic        wr_en_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i
`ifdef PTW_MEM_ERR_EN
    ,
    output logic        mem_err_o
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [29:0] idx_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] data_q;
`ifdef PTW_MEM_ERR_EN
    logic        misalign_q;
    logic        err_q;
`endif

    logic [31:0] mem [DEPTH];

    logic        rd_in_range;
    logic [31:0] rd_word;
    logic        wr_in_range;
    logic        unused_bits;

    assign rd_in_range = (idx_q < 30'(DEPTH));
    assign rd_word     = mem[idx_q[IDX_W-1:0]];
    assign wr_in_range = (wr_addr_i[31:2] < 30'(DEPTH));

    // Byte-offset bits have no effect on the stored word.
`ifdef PTW_MEM_ERR_EN
    assign unused_bits = ^wr_addr_i[1:0];
`else
    assign unused_bits = ^{wr_addr_i[1:0], mem_addr_i[1:0]};
`endif

    assign mem_req_ready_o  = req_ready_q;
    assign mem_resp_valid_o = resp_valid_q;
    assign mem_data_o       = data_q;
`ifdef PTW_MEM_ERR_EN
    assign mem_err_o        = err_q;
`endif

    // Preload write port. It has no reset, so the contents persist across rst_n.
    // It is gated off while reset is held. A read that samples the array on
    // the same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_i && wr_in_range) begin
            mem[wr_addr_i[IDX_W+1:2]] <= wr_data_i;
        end
    end

    // Request/response FSM with registered outputs. The acceptance edge does
    // not count as a latency cycle. WAIT holds the remaining count, so
    // LATENCY=1 enters WAIT with zero and moves to RESP on the next edge.
    // In every case valid rises after acceptance edge + LATENCY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            idx_q        <= 30'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            data_q       <= 32'd0;
`ifdef PTW_MEM_ERR_EN
            misalign_q   <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (mem_req_valid_i && req_ready_q) begin
                        idx_q       <= mem_addr_i[31:2];
`ifdef PTW_MEM_ERR_EN
                        misalign_q  <= (mem_addr_i[1:0] != 2'b00);
`endif
                        req_ready_q <= 1'b0;
                        cnt         <= 4'(LATENCY - 1);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
`ifdef PTW_MEM_ERR_EN
                        data_q       <= (rd_in_range && !misalign_q) ? rd_word : 32'd0;
                        err_q        <= !rd_in_range || misalign_q;
`else
                        data_q       <= rd_in_range ? rd_word : 32'd0;
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (mem_resp_ready_i) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready_q  <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptw_pt_mem.sv
// Bench for ptw_pt_mem. Three instances share the clock, reset and preload
// write port: instance 0 uses LATENCY=2, instance 1 uses LATENCY=1, and
// instance 2 uses LATENCY=4.
module tb_ptw_pt_mem;

    localparam int DEPTH = 1024;
    localparam int NI    = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 4;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic [31:0] req_addr   [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_data  [NI];
`ifdef PTW_MEM_ERR_EN
    logic        resp_err   [NI];
`endif
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ptw_pt_mem #(
            .DEPTH  (DEPTH),
            .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .mem_req_valid_i (req_valid[g]),
            .mem_req_ready_o (req_ready[g]),
            .mem_addr_i      (req_addr[g]),
            .mem_resp_valid_o(resp_valid[g]),
            .mem_resp_ready_i(resp_ready[g]),
            .mem_data_o      (resp_data[g]),
            .wr_en_i         (wr_en),
            .wr_addr_i       (wr_addr),
            .wr_data_i       (wr_data)
`ifdef PTW_MEM_ERR_EN
            ,
            .mem_err_o       (resp_err[g])
`endif
        );
    end

    // ---------------- scoreboard / reference model ----------------
    int          n_checks;
    int          n_err;
    logic [31:0] exp_q[$];
    logic [31:0] model_mem [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read result: words past the end read as zero. With the error
    // feature, a misaligned address also reads as zero and is flagged.
    function automatic logic [31:0] model_data(input logic [31:0] a);
        int unsigned idx;
        idx = a >> 2;
        if (idx >= DEPTH) return 32'd0;
`ifdef PTW_MEM_ERR_EN
        if ((a % 4) != 0) return 32'd0;
`endif
        return model_mem[idx];
    endfunction

    function automatic logic model_err(input logic [31:0] a);
`ifdef PTW_MEM_ERR_EN
        return ((a >> 2) >= DEPTH) || ((a % 4) != 0);
`else
        return (a === 32'hffff_ffff);
`endif
    endfunction

    // ---------------- driver tasks (start and end at a negedge) ----------------
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        if ((a >> 2) < DEPTH) model_mem[a >> 2] = d;
    endtask

    task automatic do_read(input int k, input logic [31:0] a, input logic [31:0] ed,
                           input logic ee, input int stall, input logic coll,
                           input logic [31:0] cdata, output int acc);
        int          t;
        int          lat;
        logic [31:0] e;
        lat = lat_of(k);
        acc = 0;
        t   = 0;
        while (!req_ready[k] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[k]) begin
            n_checks++;
            n_err++;
            $display("FAIL req_ready_timeout: inst=%0d ready stayed 0, required 1", k);
            return;
        end
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        exp_q.push_back(ed);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        req_valid[k] = 1'b0;
        check("ready_low_after_accept", 32'(req_ready[k]), 32'd0);
        for (int i = 1; i <= lat; i++) begin
            if (coll && i == lat) begin
                wr_en   = 1'b1;
                wr_addr = a;
                wr_data = cdata;
            end
            @(posedge clk);
            @(negedge clk);
            if (coll && i == lat) begin
                wr_en = 1'b0;
                if ((a >> 2) < DEPTH) model_mem[a >> 2] = cdata;
            end
            check("resp_valid_timing", 32'(resp_valid[k]), 32'(i == lat));
        end
        e = exp_q.pop_front();
        check("resp_data", resp_data[k], e);
`ifdef PTW_MEM_ERR_EN
        check("resp_err", 32'(resp_err[k]), 32'(ee));
`else
        if (ee) $display("note: error flag expectation ignored in this build");
`endif
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 32'(resp_valid[k]), 32'd1);
            check("stall_data", resp_data[k], e);
            check("stall_req_ready", 32'(req_ready[k]), 32'd0);
        end
        resp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[k] = 1'b0;
        check("valid_low_after_hs", 32'(resp_valid[k]), 32'd0);
        check("ready_high_after_hs", 32'(req_ready[k]), 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          stall;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acc_a;
        int acc_b;
        int bad;
        cyc      = 0;
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        for (int k = 0; k < NI; k++) begin
            req_valid[k]  = 1'b0;
            req_addr[k]   = '0;
            resp_ready[k] = 1'b0;
        end

        vecs[0] = '{0, 32'h0000_0400, 32'h0000_0801, 1'b0, 0};
        vecs[1] = '{0, 32'h0000_0800, 32'h1000_000F, 1'b0, 0};
        vecs[2] = '{0, 32'h0000_0804, 32'h1100_000F, 1'b0, 5};
        vecs[3] = '{0, 32'h0000_1000, 32'h0000_0000, 1'b1, 0};
`ifdef PTW_MEM_ERR_EN
        vecs[4] = '{0, 32'h0000_0402, 32'h0000_0000, 1'b1, 1};
`else
        vecs[4] = '{0, 32'h0000_0402, 32'h0000_0801, 1'b0, 1};
`endif
        vecs[5] = '{1, 32'h0000_0400, 32'h0000_0801, 1'b0, 0};
        vecs[6] = '{2, 32'h0000_0404, 32'h0000_0C01, 1'b0, 2};

        // Reset state.
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_req_ready", 32'(req_ready[k]), 32'd0);
            check("reset_resp_valid", 32'(resp_valid[k]), 32'd0);
            check("reset_data", resp_data[k], 32'd0);
        end
        rst_n = 1'b1;
        check("ready_before_first_edge", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_first_edge", 32'(req_ready[0]), 32'd1);

        // Preload the page-table entries and a random scratch region.
        do_write(32'h0000_0400, 32'h0000_0801);
        do_write(32'h0000_0404, 32'h0000_0C01);
        do_write(32'h0000_0800, 32'h1000_000F);
        do_write(32'h0000_0804, 32'h1100_000F);
        do_write(32'h0000_0808, 32'h1200_0007);
        do_write(32'h0000_1000, 32'hFFFF_FFFF);   // out of range: dropped
        for (int i = 0; i < 64; i++) do_write(32'(i * 4), $urandom);

        // Table-driven directed vectors.
        for (int v = 0; v < 7; v++) begin
            do_read(vecs[v].inst, vecs[v].addr, vecs[v].data, vecs[v].err,
                    vecs[v].stall, 1'b0, 32'd0, acc_a);
        end

        // Collision: a write on the edge that enters RESP; the response returns the old word.
        do_read(0, 32'h0000_0808, 32'h1200_0007, 1'b0, 0, 1'b1, 32'hDEAD_BEEF, acc_a);
        do_read(0, 32'h0000_0808, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'd0, acc_a);

        // LATENCY=1 back-to-back requests.
        do_read(1, 32'h0000_0400, 32'h0000_0801, 1'b0, 0, 1'b0, 32'd0, acc_a);
        do_read(1, 32'h0000_0404, 32'h0000_0C01, 1'b0, 0, 1'b0, 32'd0, acc_b);
        check("l1_accept_gap_ge2", 32'((acc_b - acc_a) >= 2), 32'd1);

        // Reset in the middle of WAIT on the LATENCY=4 instance.
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h0000_0800;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 32'h0000_0400;
        wr_data = 32'hBAD0_BAD0;             // must be ignored under reset
        #1;
        check("midwait_rst_req_ready", 32'(req_ready[2]), 32'd0);
        check("midwait_rst_resp_valid", 32'(resp_valid[2]), 32'd0);
        check("midwait_rst_data", resp_data[2], 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        bad   = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid[2] !== 1'b0) bad++;
        end
        check("no_resp_after_reset", 32'(bad), 32'd0);
        check("ready_after_reset", 32'(req_ready[2]), 32'd1);
        do_read(2, 32'h0000_0400, 32'h0000_0801, 1'b0, 0, 1'b0, 32'd0, acc_a);
        do_read(2, 32'h0000_0800, 32'h1000_000F, 1'b0, 1, 1'b0, 32'd0, acc_a);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            int          k;
            int          r;
            logic [31:0] a;
            logic        coll;
            k = $urandom_range(0, NI - 1);
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 63)) << 2;
            else if (r < 8) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            else            a = (32'($urandom_range(1024, 1200)) << 2) | 32'($urandom_range(0, 3));
            coll = (r < 7) && ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) do_write(32'($urandom_range(0, 63)) << 2, $urandom);
            do_read(k, a, model_data(a), model_err(a), $urandom_range(0, 3), coll, $urandom, acc_a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
